// File: rtl/ysyx_25010008_arbiter_if.sv
// Read/write request-response bundle between one master and one slave.
// Purely structural: no logic and no latency of its own.
// Backpressure is carried by the ready/valid pairs of each channel.
interface ysyx_25010008_arbiter_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  // Seen from the side that issues requests.
  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  // Seen from the side that answers requests.
  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_25010008_arbiter.sv
// Two-master to one-slave round-robin arbiter, one transaction at a time, with timeout.
// Grant takes one cycle from request; channels are then routed combinationally.
// Backpressure passes straight through the routed channels; losers see all-zero outputs.
module ysyx_25010008_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  ysyx_25010008_arbiter_if.slave         m0,
  ysyx_25010008_arbiter_if.slave         m1,
  ysyx_25010008_arbiter_if.master        s,
  output logic                           busy,
  output logic                           gnt
);

  typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;

  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0]       SLVERR  = 2'b10;

  state_t           state;
  logic             gnt_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt;

  // Request-side signals of the currently granted master.
  logic [31:0] sel_araddr, sel_awaddr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_arvalid, sel_awvalid, sel_wvalid, sel_rready, sel_bready;

  assign sel_araddr  = gnt_q ? m1.araddr  : m0.araddr;
  assign sel_awaddr  = gnt_q ? m1.awaddr  : m0.awaddr;
  assign sel_wdata   = gnt_q ? m1.wdata   : m0.wdata;
  assign sel_wstrb   = gnt_q ? m1.wstrb   : m0.wstrb;
  assign sel_arvalid = gnt_q ? m1.arvalid : m0.arvalid;
  assign sel_awvalid = gnt_q ? m1.awvalid : m0.awvalid;
  assign sel_wvalid  = gnt_q ? m1.wvalid  : m0.wvalid;
  assign sel_rready  = gnt_q ? m1.rready  : m0.rready;
  assign sel_bready  = gnt_q ? m1.bready  : m0.bready;

  // Arbitration inputs, only consulted in IDLE.
  logic req0, req1, pick, pick_rd;
  assign req0    = m0.arvalid | m0.awvalid;
  assign req1    = m1.arvalid | m1.awvalid;
  // On a tie the master that was not served last wins; otherwise the lone requester.
  assign pick    = (req0 & req1) ? ~last_q : req1;
  // Reads go first when the winner has both a read and a write pending.
  assign pick_rd = pick ? m1.arvalid : m0.arvalid;

  // Exit handshakes and timeout detection.
  logic             rd_done, wr_done, tmo;
  logic [CNT_W-1:0] cnt_inc;
  assign rd_done = s.rvalid & sel_rready;
  assign wr_done = s.bvalid & sel_bready;
  assign cnt_inc = cnt + 1'b1;
  // The counter reaches TIMEOUT at the edge ending the TIMEOUT-th cycle of the transaction.
  assign tmo     = (TIMEOUT != 0) && (cnt_inc == TMO);

  // While in ERR the counter is otherwise idle, so its LSB records which channel timed out.
  logic err_wr;
  assign err_wr = cnt[0];

  // Transaction FSM: grant, channel, last-served pointer and cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      gnt_q  <= 1'b0;
      last_q <= 1'b1;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt_q <= pick;
            state <= pick_rd ? RD : WR;
            cnt   <= '0;
          end
        end
        RD: begin
          if (rd_done) begin
            state  <= IDLE;
            last_q <= gnt_q;
          end else if (tmo) begin
            state <= ERR;
            cnt   <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt_inc;
          end
        end
        WR: begin
          if (wr_done) begin
            state  <= IDLE;
            last_q <= gnt_q;
          end else if (tmo) begin
            state <= ERR;
            cnt   <= CNT_W'(1);
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt_inc;
          end
        end
        ERR: begin
          if (err_wr ? sel_bready : sel_rready) begin
            state  <= IDLE;
            last_q <= gnt_q;
            cnt    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign gnt  = gnt_q;

  // Slave-facing outputs: forward only the channels of the active transaction type.
  always_comb begin
    s.araddr  = '0;
    s.arvalid = 1'b0;
    s.rready  = 1'b0;
    s.awaddr  = '0;
    s.awvalid = 1'b0;
    s.wdata   = '0;
    s.wstrb   = '0;
    s.wvalid  = 1'b0;
    s.bready  = 1'b0;
    case (state)
      RD: begin
        s.araddr  = sel_araddr;
        s.arvalid = sel_arvalid;
        s.rready  = sel_rready;
      end
      WR: begin
        s.awaddr  = sel_awaddr;
        s.awvalid = sel_awvalid;
        s.wdata   = sel_wdata;
        s.wstrb   = sel_wstrb;
        s.wvalid  = sel_wvalid;
        s.bready  = sel_bready;
      end
      default: ;
    endcase
  end

  // Response view presented to the granted master; ERR synthesises a slave-error response.
  logic        g_arready, g_rvalid, g_awready, g_wready, g_bvalid;
  logic [31:0] g_rdata;
  logic [1:0]  g_rresp, g_bresp;

  always_comb begin
    g_arready = 1'b0;
    g_rvalid  = 1'b0;
    g_rdata   = '0;
    g_rresp   = '0;
    g_awready = 1'b0;
    g_wready  = 1'b0;
    g_bvalid  = 1'b0;
    g_bresp   = '0;
    case (state)
      RD: begin
        g_arready = s.arready;
        g_rvalid  = s.rvalid;
        g_rdata   = s.rdata;
        g_rresp   = s.rresp;
      end
      WR: begin
        g_awready = s.awready;
        g_wready  = s.wready;
        g_bvalid  = s.bvalid;
        g_bresp   = s.bresp;
      end
      ERR: begin
        if (err_wr) begin
          g_bvalid = 1'b1;
          g_bresp  = SLVERR;
        end else begin
          g_rvalid = 1'b1;
          g_rresp  = SLVERR;
        end
      end
      default: ;
    endcase
  end

  // Steer the granted view to one master; the other sees zeros.
  assign m0.arready = gnt_q ? 1'b0  : g_arready;
  assign m0.rvalid  = gnt_q ? 1'b0  : g_rvalid;
  assign m0.rdata   = gnt_q ? '0    : g_rdata;
  assign m0.rresp   = gnt_q ? '0    : g_rresp;
  assign m0.awready = gnt_q ? 1'b0  : g_awready;
  assign m0.wready  = gnt_q ? 1'b0  : g_wready;
  assign m0.bvalid  = gnt_q ? 1'b0  : g_bvalid;
  assign m0.bresp   = gnt_q ? '0    : g_bresp;

  assign m1.arready = gnt_q ? g_arready : 1'b0;
  assign m1.rvalid  = gnt_q ? g_rvalid  : 1'b0;
  assign m1.rdata   = gnt_q ? g_rdata   : '0;
  assign m1.rresp   = gnt_q ? g_rresp   : '0;
  assign m1.awready = gnt_q ? g_awready : 1'b0;
  assign m1.wready  = gnt_q ? g_wready  : 1'b0;
  assign m1.bvalid  = gnt_q ? g_bvalid  : 1'b0;
  assign m1.bresp   = gnt_q ? g_bresp   : '0;

endmodule

// File: tb/tb_ysyx_25010008_arbiter.sv
// Directed bench for the two-master arbiter: arbitration table plus read, write,
// timeout and mid-transaction reset sequences.
module tb_ysyx_25010008_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, gnt;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ysyx_25010008_arbiter_if m0_if();
  ysyx_25010008_arbiter_if m1_if();
  ysyx_25010008_arbiter_if s_if();

  ysyx_25010008_arbiter #(.TIMEOUT(8), .CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .m0   (m0_if),
    .m1   (m1_if),
    .s    (s_if),
    .busy (busy),
    .gnt  (gnt)
  );

  typedef struct packed {
    logic m0_ar;
    logic m0_aw;
    logic m1_ar;
    logic m1_aw;
    logic exp_gnt;
    logic exp_rd;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.arvalid = 0; m0_if.awvalid = 0; m0_if.wvalid = 0; m0_if.rready = 0; m0_if.bready = 0;
    m1_if.arvalid = 0; m1_if.awvalid = 0; m1_if.wvalid = 0; m1_if.rready = 0; m1_if.bready = 0;
    m0_if.araddr = 0; m0_if.awaddr = 0; m0_if.wdata = 0; m0_if.wstrb = 0;
    m1_if.araddr = 0; m1_if.awaddr = 0; m1_if.wdata = 0; m1_if.wstrb = 0;
    s_if.arready = 0; s_if.awready = 0; s_if.wready = 0;
    s_if.rvalid = 0; s_if.rdata = 0; s_if.rresp = 0; s_if.bvalid = 0; s_if.bresp = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    vec_t v;

    // Arbitration table; pointer starts at 1 so master 0 wins the first tie.
    vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state, with requests and slave readiness deliberately asserted.
    clear_inputs();
    m0_if.arvalid = 1; m1_if.awvalid = 1; s_if.arready = 1; s_if.awready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_m0_arready", m0_if.arready, 0);
    chk("rst_m1_awready", m1_if.awready, 0);
    chk("rst_s_valids", {s_if.arvalid, s_if.awvalid, s_if.wvalid}, 0);
    clear_inputs();
    rst = 1;

    // Table: one full transaction per vector.
    for (int i = 0; i < 10; i++) begin
      v = vt[i];
      tick();
      m0_if.arvalid = v.m0_ar; m0_if.awvalid = v.m0_aw; m0_if.wvalid = v.m0_aw;
      m1_if.arvalid = v.m1_ar; m1_if.awvalid = v.m1_aw; m1_if.wvalid = v.m1_aw;
      m0_if.araddr = 32'h100 + 32'(i); m1_if.araddr = 32'h200 + 32'(i);
      m0_if.awaddr = 32'h300 + 32'(i); m1_if.awaddr = 32'h400 + 32'(i);
      m0_if.wdata  = 32'h500 + 32'(i); m1_if.wdata  = 32'h600 + 32'(i);
      m0_if.rready = 1; m0_if.bready = 1; m1_if.rready = 1; m1_if.bready = 1;
      s_if.arready = 1; s_if.awready = 1; s_if.wready = 1;
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
      chk($sformatf("v%0d_idle_fwd", i), {s_if.arvalid, s_if.awvalid}, 0);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_busy", i), busy, 1);
      chk($sformatf("v%0d_gnt", i), gnt, v.exp_gnt);
      chk($sformatf("v%0d_s_arvalid", i), s_if.arvalid, v.exp_rd);
      chk($sformatf("v%0d_s_awvalid", i), s_if.awvalid, !v.exp_rd);
      if (v.exp_rd) begin
        exp_addr = (v.exp_gnt ? 32'h200 : 32'h100) + 32'(i);
        chk($sformatf("v%0d_s_araddr", i), s_if.araddr, exp_addr);
      end else begin
        exp_addr = (v.exp_gnt ? 32'h400 : 32'h300) + 32'(i);
        exp_wd   = (v.exp_gnt ? 32'h600 : 32'h500) + 32'(i);
        chk($sformatf("v%0d_s_awaddr", i), s_if.awaddr, exp_addr);
        chk($sformatf("v%0d_s_wdata", i), s_if.wdata, exp_wd);
      end
      if (v.exp_gnt)
        chk($sformatf("v%0d_loser_rdy", i), {m0_if.arready, m0_if.awready, m0_if.wready}, 0);
      else
        chk($sformatf("v%0d_loser_rdy", i), {m1_if.arready, m1_if.awready, m1_if.wready}, 0);
      tick();
      m0_if.arvalid = 0; m0_if.awvalid = 0; m0_if.wvalid = 0;
      m1_if.arvalid = 0; m1_if.awvalid = 0; m1_if.wvalid = 0;
      if (v.exp_rd) begin
        s_if.rvalid = 1; s_if.rdata = 32'hA000_0000 + 32'(i); s_if.rresp = 0;
      end else begin
        s_if.bvalid = 1; s_if.bresp = 0;
      end
      @(negedge clk);
      if (v.exp_rd) begin
        chk($sformatf("v%0d_rvalid", i), v.exp_gnt ? m1_if.rvalid : m0_if.rvalid, 1);
        chk($sformatf("v%0d_rdata", i), v.exp_gnt ? m1_if.rdata : m0_if.rdata, 32'hA000_0000 + 32'(i));
        chk($sformatf("v%0d_loser_rvalid", i), v.exp_gnt ? m0_if.rvalid : m1_if.rvalid, 0);
      end else begin
        chk($sformatf("v%0d_bvalid", i), v.exp_gnt ? m1_if.bvalid : m0_if.bvalid, 1);
        chk($sformatf("v%0d_loser_bvalid", i), v.exp_gnt ? m0_if.bvalid : m1_if.bvalid, 0);
      end
      tick();
      s_if.rvalid = 0; s_if.bvalid = 0; s_if.rdata = 0;
      @(negedge clk);
      chk($sformatf("v%0d_done_busy", i), busy, 0);
    end

    // Single read from m0 with a three-cycle slave latency.
    clear_inputs();
    tick();
    m0_if.arvalid = 1; m0_if.araddr = 32'h8000_0010; s_if.arready = 1;
    tick();
    @(negedge clk);
    chk("rd_s_araddr", s_if.araddr, 32'h8000_0010);
    chk("rd_m0_arready", m0_if.arready, 1);
    tick();
    m0_if.arvalid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rd_wait%0d_rvalid", k), m0_if.rvalid, 0);
      tick();
    end
    s_if.rvalid = 1; s_if.rdata = 32'hDEAD_BEEF; s_if.rresp = 0; m0_if.rready = 1;
    @(negedge clk);
    chk("rd_rvalid", m0_if.rvalid, 1);
    chk("rd_rdata", m0_if.rdata, 32'hDEAD_BEEF);
    chk("rd_rresp", m0_if.rresp, 0);
    chk("rd_busy_hs", busy, 1);
    tick();
    s_if.rvalid = 0;
    @(negedge clk);
    chk("rd_busy_after", busy, 0);

    // Write from m1 with W accepted before AW.
    clear_inputs();
    tick();
    m1_if.awvalid = 1; m1_if.awaddr = 32'h1000_0000; m1_if.wvalid = 1;
    m1_if.wdata = 32'h41; m1_if.wstrb = 4'b0001; s_if.wready = 1; s_if.awready = 0;
    tick();
    @(negedge clk);
    chk("wr_gnt", gnt, 1);
    chk("wr_s_awaddr", s_if.awaddr, 32'h1000_0000);
    chk("wr_s_wdata", s_if.wdata, 32'h41);
    chk("wr_s_wstrb", s_if.wstrb, 4'b0001);
    chk("wr_w_first", {m1_if.wready, m1_if.awready}, 2'b10);
    chk("wr_s_arvalid", s_if.arvalid, 0);
    tick();
    m1_if.wvalid = 0; s_if.awready = 1;
    @(negedge clk);
    chk("wr_aw_second", {s_if.wvalid, m1_if.awready}, 2'b01);
    tick();
    m1_if.awvalid = 0; s_if.bvalid = 1; s_if.bresp = 0; m1_if.bready = 1;
    @(negedge clk);
    chk("wr_bvalid", m1_if.bvalid, 1);
    chk("wr_bresp", m1_if.bresp, 0);
    chk("wr_m0_quiet", {m0_if.awready, m0_if.wready, m0_if.bvalid, m0_if.arready, m0_if.rvalid}, 0);
    tick();
    s_if.bvalid = 0;
    @(negedge clk);
    chk("wr_busy_after", busy, 0);

    // Read timeout on m0: the slave never answers.
    clear_inputs();
    tick();
    m0_if.arvalid = 1; m0_if.araddr = 32'h8000_0020; s_if.arready = 1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("to_rd_cyc%0d_rvalid", k), m0_if.rvalid, 0);
      tick();
      m0_if.arvalid = 0;
    end
    s_if.rvalid = 1; s_if.rdata = 32'h1234_5678; s_if.rresp = 0;
    @(negedge clk);
    chk("to_rd_rvalid", m0_if.rvalid, 1);
    chk("to_rd_rresp", m0_if.rresp, 2'b10);
    chk("to_rd_rdata", m0_if.rdata, 0);
    chk("to_rd_bvalid", m0_if.bvalid, 0);
    chk("to_rd_s_quiet", {s_if.arvalid, s_if.rready}, 0);
    tick();
    @(negedge clk);
    chk("to_rd_hold", {busy, m0_if.rvalid}, 2'b11);
    tick();
    m0_if.rready = 1; s_if.rvalid = 0;
    @(negedge clk);
    chk("to_rd_busy_hs", busy, 1);
    tick();
    m0_if.rready = 0;
    @(negedge clk);
    chk("to_rd_busy_after", busy, 0);

    // Pointer was updated by the error exit: m1 wins the next tie.
    clear_inputs();
    tick();
    m0_if.arvalid = 1; m1_if.arvalid = 1; s_if.arready = 1;
    m0_if.rready = 1; m1_if.rready = 1;
    tick();
    @(negedge clk);
    chk("post_to_gnt", gnt, 1);
    tick();
    m0_if.arvalid = 0; m1_if.arvalid = 0;
    s_if.rvalid = 1; s_if.rdata = 32'h55;
    tick();
    s_if.rvalid = 0;
    @(negedge clk);
    chk("post_to_busy", busy, 0);

    // Write timeout on m1: bvalid with SLVERR.
    clear_inputs();
    tick();
    m1_if.awvalid = 1; m1_if.wvalid = 1; s_if.awready = 1; s_if.wready = 1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("to_wr_cyc%0d_bvalid", k), m1_if.bvalid, 0);
      tick();
      m1_if.awvalid = 0; m1_if.wvalid = 0;
    end
    @(negedge clk);
    chk("to_wr_bvalid", m1_if.bvalid, 1);
    chk("to_wr_bresp", m1_if.bresp, 2'b10);
    chk("to_wr_rvalid", m1_if.rvalid, 0);
    chk("to_wr_s_bready", s_if.bready, 0);
    tick();
    m1_if.bready = 1;
    tick();
    m1_if.bready = 0;
    @(negedge clk);
    chk("to_wr_busy_after", busy, 0);

    // Reset asserted in the middle of a write from m1.
    clear_inputs();
    tick();
    m1_if.awvalid = 1; m1_if.wvalid = 1; m1_if.awaddr = 32'h1000_0004;
    tick();
    @(negedge clk);
    chk("mr_busy", busy, 1);
    tick();
    s_if.awready = 1; s_if.wready = 1; s_if.bvalid = 1; m1_if.bready = 0;
    #2 rst = 0;
    #1;
    chk("mr_busy_rst", busy, 0);
    chk("mr_rdy_rst", {m1_if.awready, m1_if.wready, m1_if.bvalid, m1_if.rvalid}, 0);
    chk("mr_s_rst", {s_if.awvalid, s_if.wvalid, s_if.bready}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mr_hold_rst", {busy, m1_if.bvalid, s_if.awvalid}, 0);
    s_if.bvalid = 0;
    rst = 1;
    #1;
    chk("mr_release_busy", busy, 0);
    tick();
    chk("mr_regrant_busy", busy, 1);
    chk("mr_regrant_gnt", gnt, 1);
    chk("mr_regrant_aw", s_if.awaddr, 32'h1000_0004);
    m1_if.awvalid = 0; m1_if.wvalid = 0;
    s_if.bvalid = 1; m1_if.bready = 1;
    @(negedge clk);
    chk("mr_bvalid", m1_if.bvalid, 1);
    tick();
    s_if.bvalid = 0;
    @(negedge clk);
    chk("mr_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25010008_arbiter.md
YSYX_25010008_ARBITER -- requirements
Module: ysyx_25010008_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: cycle budget per granted transaction; 0 disables the timeout.
REQ-002 Parameter CNT_W, default 8: width of the timeout counter; TIMEOUT SHALL fit in CNT_W bits.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 mN_araddr / mN_awaddr  in  32  read/write address from master N (N = 0, 1; one port per N).
REQ-006 mN_arvalid, mN_awvalid, mN_wvalid, mN_rready, mN_bready  in  1 each  master N handshake inputs.
REQ-007 mN_wdata  in  32 and mN_wstrb  in  4  master N write data and byte strobes.
REQ-008 mN_arready, mN_awready, mN_wready, mN_rvalid, mN_bvalid  out  1 each  master N handshake outputs.
REQ-009 mN_rdata  out  32 and mN_rresp, mN_bresp  out  2 each  master N read data and responses.
REQ-010 s_araddr, s_awaddr, s_wdata  out  32 each and s_wstrb  out  4  slave request fields.
REQ-011 s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready  out  1 each  slave handshake outputs.
REQ-012 s_arready, s_awready, s_wready, s_rvalid, s_bvalid  in  1 each and s_rdata  in  32 and s_rresp, s_bresp  in  2 each  slave returns.
REQ-013 busy  out  1  transaction in progress; gnt  out  1  index of granted master (valid while busy).

Function
REQ-014 States: IDLE, RD, WR, ERR; the state register, grant register, last-served pointer and counter SHALL be the only state.
REQ-015 Request of master N is mN_arvalid | mN_awvalid; it is sampled only in IDLE.
REQ-016 Arbitration in IDLE with exactly one requester: grant it.
REQ-017 Arbitration in IDLE with both requesting: grant the master not equal to the last-served pointer (round-robin).
REQ-018 Arbitration: a granted master asserting both arvalid and awvalid SHALL be given the read first (IDLE->RD); the write is arbitrated again afterwards.
REQ-019 Grant is registered: state leaves IDLE one cycle after the request is seen; no channel is forwarded in IDLE.
REQ-020 RD: route AR and R between the granted master and the slave combinationally; all other master outputs SHALL be 0.
REQ-021 RD exits to IDLE on the cycle after s_rvalid & s_rready.
REQ-022 WR: route AW, W and B between the granted master and the slave; AW and W may complete in either order or together.
REQ-023 WR exits to IDLE on the cycle after s_bvalid & s_bready.
REQ-024 Every transaction exit from RD or WR SHALL set the last-served pointer to gnt.
REQ-025 Ungranted master: all ready/valid outputs 0, data and resp outputs 0.
REQ-026 Slave outputs SHALL be 0 in IDLE and ERR.
REQ-027 Counter: cleared on entry to RD/WR and incremented each cycle in RD/WR.
REQ-028 Timeout: if TIMEOUT != 0 and the counter equals TIMEOUT before the exit handshake, go to ERR; the counter SHALL never wrap.
REQ-029 ERR: drive mN_rvalid (if from RD) or mN_bvalid (if from WR) = 1 with resp 2'b10 and rdata 0 until mN_rready/mN_bready; then go to IDLE and update the pointer.
REQ-030 Slave returns arriving in ERR SHALL be ignored.
REQ-031 busy = (state != IDLE); gnt holds its value in IDLE.

Reset
REQ-032 rst low SHALL immediately force state IDLE, gnt 0, pointer 1 (master 0 wins the first tie), counter 0, busy 0.
REQ-033 While rst is low, all valid/ready outputs SHALL be 0.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction with no response to any master.
REQ-035 Leaving reset: the first arbitration occurs on the first rising edge with rst high.

Verification
REQ-036 Single read: m0 araddr 0x8000_0010, slave returns rdata 0xDEAD_BEEF resp 0 after 3 cycles -> m0 gets rvalid, rdata 0xDEAD_BEEF, busy falls 1 cycle after the handshake.
REQ-037 Contention: m0 and m1 assert arvalid the cycle after reset -> m0 served first, then m1, then m0 again if it re-requests (alternation over 4 transactions).
REQ-038 Write: m1 awaddr 0x1000_0000, wdata 0x41, wstrb 4'b0001, W before AW -> slave sees the same fields, m1 gets bvalid bresp 0, m0 outputs stay 0.
REQ-039 Timeout: TIMEOUT=8, slave never responds to m0 read -> after 8 cycles in RD, m0 rvalid=1, rresp 2'b10, rdata 0, state returns to IDLE after rready.
REQ-040 Reset mid-WR: rst low during WR -> busy 0 and all valid/ready 0 immediately; after release, m1 request is granted normally.
